// File: rtl/tinyalu_issue_ctrl.sv
// Issue stage in front of the TinyALU core. Instruction words are buffered in a
// small FIFO, decoded and driven to the ALU over the start/done handshake, and the
// completed instruction is returned on a valid/ready response port. A watchdog
// turns a missing alu_done into an error response.
module tinyalu_issue_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [18:0]              in_instr,
  output logic [7:0]               alu_A,
  output logic [7:0]               alu_B,
  output logic [2:0]               alu_op,
  output logic                     alu_start,
  input  logic                     alu_done,
  input  logic [15:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_op,
  output logic [7:0]               out_A,
  output logic [7:0]               out_B,
  output logic [15:0]              out_result,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpAdd   = 3'b001;
  localparam logic [2:0] OpAnd   = 3'b010;
  localparam logic [2:0] OpXor   = 3'b011;
  localparam logic [2:0] OpMul   = 3'b100;
  localparam logic [2:0] OpFlush = 3'b111;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q;
  logic [18:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [WDW-1:0]  wd_q;
  logic            issue_q;

  logic [18:0]     head;
  logic [2:0]      head_op;
  logic            push, pop, flush_pop;

  assign head      = mem_q[rd_ptr_q];
  assign head_op   = head[18:16];
  assign pop       = (state_q == StIdle) && (count_q != '0);
  assign flush_pop = pop && (head_op == OpFlush);
  // A full FIFO refuses a push even if a pop frees a slot this cycle.
  assign in_ready  = reset_n && (count_q < CW'(DEPTH)) && !flush_pop;
  assign push      = in_valid && in_ready;

  // Start is dropped combinationally in the cycle done is seen.
  assign alu_start  = issue_q & ~alu_done;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_count = count_q;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  // FIFO pointers and occupancy; a flush word empties the whole buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_pop) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Issue FSM with registered ALU and response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      issue_q    <= 1'b0;
      wd_q       <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_A      <= '0;
      out_B      <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop && !flush_pop) begin
            out_op <= head_op;
            out_A  <= head[15:8];
            out_B  <= head[7:0];
            case (head_op)
              OpAdd, OpAnd, OpXor, OpMul: begin
                alu_A   <= head[15:8];
                alu_B   <= head[7:0];
                alu_op  <= head_op;
                issue_q <= 1'b1;
                wd_q    <= '0;
                state_q <= StIssue;
              end
              OpNop: begin
                out_result <= '0;
                out_err    <= 1'b0;
                out_valid  <= 1'b1;
                state_q    <= StResp;
              end
              default: begin
                // 101/110 are illegal and bypass the ALU.
                out_result <= '0;
                out_err    <= 1'b1;
                out_valid  <= 1'b1;
                state_q    <= StResp;
              end
            endcase
          end
        end
        StIssue: begin
          if (alu_done) begin
            // Done has priority over a simultaneous timeout.
            out_result <= alu_result;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            issue_q    <= 1'b0;
            wd_q       <= '0;
            state_q    <= StResp;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            out_result <= '0;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            issue_q    <= 1'b0;
            wd_q       <= '0;
            state_q    <= StResp;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_issue_ctrl.sv
// Scoreboard bench for tinyalu_issue_ctrl: directed words with hand-computed
// expected responses, a behavioural ALU stand-in, and a response monitor.
module tb_tinyalu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] in_instr;
  logic [7:0]  alu_A, alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [7:0]  out_A, out_B;
  logic [15:0] out_result;
  logic        out_err;
  logic        busy;
  logic [2:0]  fifo_count;

  int compared   = 0;
  int mismatched = 0;

  // {op, A, B, result, err}
  logic [35:0] exp_q[$];

  int alu_lat      = 1;
  bit alu_hang     = 1'b0;
  int start_cycles = 0;
  int alu_cnt      = 0;

  tinyalu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_A      (out_A),
    .out_B      (out_B),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // ALU stand-in: done pulses alu_lat cycles after start is first seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        alu_done = 1'b0;
        alu_cnt  = 0;
      end else if (alu_done) begin
        alu_done = 1'b0;
      end else if (alu_start) begin
        start_cycles++;
        alu_cnt++;
        if (!alu_hang && alu_cnt >= alu_lat) begin
          alu_result = alu_fn(alu_op, alu_A, alu_B);
          alu_done   = 1'b1;
          alu_cnt    = 0;
        end
      end else begin
        alu_cnt = 0;
      end
    end
  end

  // Response monitor: every handshake is matched against the scoreboard head.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_resp: got op=%0d A=0x%0h B=0x%0h res=0x%0h err=%0d, expected none",
                   out_op, out_A, out_B, out_result, out_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_op",     32'(out_op),     32'(e[35:33]));
          check("resp_A",      32'(out_A),      32'(e[32:25]));
          check("resp_B",      32'(out_B),      32'(e[24:17]));
          check("resp_result", 32'(out_result), 32'(e[16:1]));
          check("resp_err",    32'(out_err),    32'(e[0]));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [18:0] w);
    int k;
    in_valid = 1'b1;
    in_instr = w;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [18:0] w, input logic [15:0] res, input logic err);
    exp_q.push_back({w, res, err});
    push(w);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_and_check(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_alu_start"},  32'(alu_start),  32'd0);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_alu_start",  32'(alu_start),  32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_alu_A",      32'(alu_A),      32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_out_valid",  32'(out_valid),  32'd0);
    check("rel_alu_start",  32'(alu_start),  32'd0);
    check("rel_fifo_count", 32'(fifo_count), 32'd0);
    check("rel_busy",       32'(busy),       32'd0);
    @(posedge clk);
    #1;

    // Single add through a 1-cycle ALU.
    start_cycles = 0;
    alu_lat      = 1;
    push_exp({3'b001, 8'h12, 8'h34}, 16'h0046, 1'b0);
    wait_idle();
    check("add_start_cycles", 32'(start_cycles), 32'd1);

    // Fill the FIFO behind a stalled response; one word is in flight, four buffered.
    start_cycles = 0;
    out_ready    = 1'b0;
    push_exp({3'b100, 8'h03, 8'h04}, 16'h000C, 1'b0);
    push_exp({3'b100, 8'h10, 8'h10}, 16'h0100, 1'b0);
    push_exp({3'b100, 8'hFF, 8'hFF}, 16'hFE01, 1'b0);
    push_exp({3'b100, 8'h07, 8'h08}, 16'h0038, 1'b0);
    push_exp({3'b100, 8'h80, 8'h02}, 16'h0100, 1'b0);
    @(negedge clk);
    check("full_count",    32'(fifo_count), 32'd4);
    check("full_in_ready", 32'(in_ready),   32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_instr = {3'b100, 8'h02, 8'h03};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("full_refuse_count", 32'(fifo_count), 32'd4);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    push_exp({3'b100, 8'h02, 8'h03}, 16'h0006, 1'b0);
    wait_idle();
    check("full_start_cycles", 32'(start_cycles), 32'd6);

    // Illegal opcode and no-op bypass the ALU.
    start_cycles = 0;
    push_exp({3'b101, 8'hAA, 8'h55}, 16'h0000, 1'b1);
    push_exp({3'b000, 8'h00, 8'h00}, 16'h0000, 1'b0);
    wait_idle();
    check("bypass_start_cycles", 32'(start_cycles), 32'd0);

    // Watchdog timeout, then a normal add.
    start_cycles = 0;
    alu_hang     = 1'b1;
    push_exp({3'b100, 8'h09, 8'h09}, 16'h0000, 1'b1);
    wait_idle();
    check("timeout_start_cycles", 32'(start_cycles), 32'd16);
    alu_hang     = 1'b0;
    alu_lat      = 2;
    start_cycles = 0;
    push_exp({3'b001, 8'hFF, 8'h01}, 16'h0100, 1'b0);
    wait_idle();
    check("post_timeout_start_cycles", 32'(start_cycles), 32'd2);

    // Flush word drops the queued 'and'.
    alu_lat      = 6;
    start_cycles = 0;
    push_exp({3'b001, 8'h05, 8'h07}, 16'h000C, 1'b0);
    push_exp({3'b011, 8'hF0, 8'h3C}, 16'h00CC, 1'b0);
    push({3'b111, 8'h00, 8'h00});
    push({3'b010, 8'hFF, 8'h0F});
    wait_idle();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("flush_count",        32'(fifo_count),   32'd0);
    check("flush_start_cycles", 32'(start_cycles), 32'd12);
    @(posedge clk);
    #1;

    // Reset mid-ISSUE with a word still buffered.
    alu_lat = 10;
    push({3'b001, 8'h01, 8'h01});
    push({3'b011, 8'h02, 8'h02});
    k = 0;
    @(negedge clk);
    while (!alu_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mid_issue_start", 32'(alu_start),  32'd1);
    check("mid_issue_count", 32'(fifo_count), 32'd1);
    pulse_reset_and_check("rst_issue");
    repeat (25) @(posedge clk);
    #1;

    // Reset mid-RESP.
    out_ready = 1'b0;
    push({3'b000, 8'h03, 8'h03});
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mid_resp_valid", 32'(out_valid), 32'd1);
    pulse_reset_and_check("rst_resp");
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Recovery after reset.
    alu_lat = 1;
    push_exp({3'b010, 8'h3C, 8'h0F}, 16'h000C, 1'b0);
    wait_idle();
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global safety net.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
